// File: rtl/id_hazard_ctrl_pkg.sv
// id_hazard_ctrl_pkg: opcode classes, NOP and FSM encoding shared by the decode stage
package id_hazard_ctrl_pkg;
  localparam logic [4:0] OP_R       = 5'b01100;
  localparam logic [4:0] OP_R_W     = 5'b01110;
  localparam logic [4:0] OP_I_ARITH = 5'b00100;
  localparam logic [4:0] OP_I_W     = 5'b00110;
  localparam logic [4:0] OP_I_LOAD  = 5'b00000;
  localparam logic [4:0] OP_S       = 5'b01000;
  localparam logic [4:0] OP_B       = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
endpackage

// File: rtl/id_hazard_ctrl_if.sv
// id_hazard_ctrl_if: fetch, EX and issue signals around the ID register
interface id_hazard_ctrl_if #(parameter int XLEN = 64);
  logic if_valid, if_ready, ex_ready, ex_valid, ex_is_load, ex_redirect, issue_valid;
  logic [31:0] if_inst, issue_inst;
  logic [XLEN-1:0] if_pc, issue_pc;
  logic [4:0] ex_rd;
  modport master (
    output if_valid, if_inst, if_pc, ex_ready, ex_valid, ex_is_load, ex_rd, ex_redirect,
    input  if_ready, issue_valid, issue_inst, issue_pc
  );
  modport slave (
    input  if_valid, if_inst, if_pc, ex_ready, ex_valid, ex_is_load, ex_rd, ex_redirect,
    output if_ready, issue_valid, issue_inst, issue_pc
  );
endinterface

// File: rtl/id_src_use_dec.sv
// id_src_use_dec: which source registers an opcode class reads
module id_src_use_dec
  import id_hazard_ctrl_pkg::*;
(
  input  logic [4:0] op,
  output logic       uses_rs1,
  output logic       uses_rs2
);
  logic known;
  always_comb begin
    known = op inside {OP_R, OP_R_W, OP_I_ARITH, OP_I_W, OP_I_LOAD, OP_S, OP_B, OP_JALR,
                       OP_JAL, OP_LUI, OP_AUIPC};
    uses_rs1 = known & ~(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    uses_rs2 = op inside {OP_R, OP_R_W, OP_S, OP_B};
  end
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: IF/ID register with load-use bubble, redirect flush and perf counters
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_hazard_ctrl_if.slave  b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state, state_nx;
  logic id_valid;
  logic [31:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [2:0] fcnt, fcnt_nx;
  logic uses_rs1, uses_rs2, hazard, fire, load, stall_inc;
  id_src_use_dec u_dec (.op(id_inst[6:2]), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2));
  // id_valid is always 0 in FLUSH, so ~id_valid already keeps fetch draining there
  always_comb begin
    hazard = id_valid & b.ex_valid & b.ex_is_load & (b.ex_rd != 5'd0) &
             ((uses_rs1 & (id_inst[19:15] == b.ex_rd)) | (uses_rs2 & (id_inst[24:20] == b.ex_rd)));
    b.issue_valid = state == FLUSH ? 1'b0 : state == STALL ? id_valid : id_valid & ~hazard;
    b.issue_inst = id_inst;
    b.issue_pc = id_pc;
    fire = b.issue_valid & b.ex_ready;
    b.if_ready = ~id_valid | fire;
    load = (state != FLUSH) & b.if_ready & ~b.ex_redirect;
    stall_inc = (state == RUN) & hazard & ~b.ex_redirect;
    state_nx = b.ex_redirect ? FLUSH :
               stall_inc ? STALL :
               state == STALL ? RUN :
               (state == FLUSH & b.if_valid & fcnt == 3'd1) ? RUN : state;
    fcnt_nx = b.ex_redirect ? 3'(FLUSH_CYCLES) :
              (state == FLUSH & b.if_valid) ? fcnt - 3'd1 : fcnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt <= 3'd0;
      id_valid <= 1'b0;
      id_inst <= NOP;
      id_pc <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      fcnt <= fcnt_nx;
      if (b.ex_redirect) id_valid <= 1'b0;
      else if (load) id_valid <= b.if_valid;
      if (load & b.if_valid) begin
        id_inst <= b.if_inst;
        id_pc <= b.if_pc;
      end
      if (stall_inc & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (b.ex_redirect & ~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed and random checks of id_hazard_ctrl against a cycle model
module tb_id_hazard_ctrl;
  localparam int XLEN = 64;
  localparam int FC = 1;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] ADD  = 32'h0072_8333;
  localparam logic [31:0] LUI  = 32'h0002_8337;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int vectors = 0;
  int miscompares = 0;
  int m_mode, m_fc, m_sc, m_fl;
  bit m_v;
  logic [31:0] m_inst;
  logic [XLEN-1:0] m_pc;
  logic [4:0] ops [12] = '{5'b01100, 5'b01110, 5'b00100, 5'b00110, 5'b00000, 5'b01000,
                           5'b11000, 5'b11001, 5'b11011, 5'b01101, 5'b00101, 5'b11111};
  id_hazard_ctrl_if #(.XLEN(XLEN)) bus ();
  id_hazard_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .b(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  function automatic bit [1:0] uses(input logic [31:0] i);
    case (i[6:2])
      5'b01100, 5'b01110, 5'b01000, 5'b11000: return 2'b11;
      5'b00100, 5'b00110, 5'b00000, 5'b11001: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [31:0] i = $urandom;
    i[6:0] = {ops[$urandom_range(0, 11)], 2'b11};
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_fc = 0; m_sc = 0; m_fl = 0; m_v = 0; m_inst = NOP; m_pc = '0;
  endtask
  task automatic check_outputs(input bit eiv, input bit eir);
    chk("issue_valid", 64'(bus.issue_valid), 64'(eiv));
    chk("if_ready", 64'(bus.if_ready), 64'(eir));
    chk("issue_inst", 64'(bus.issue_inst), 64'(m_inst));
    chk("issue_pc", 64'(bus.issue_pc), 64'(m_pc));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_fl));
  endtask
  // one cycle: drive, compare against the model, advance the model, clock
  task automatic step(input bit ifv, input logic [31:0] inst, input logic [XLEN-1:0] pc,
                      input bit exr, input bit exv, input bit exl, input logic [4:0] rd,
                      input bit red);
    bit haz, eiv, eir;
    bit [1:0] u;
    bus.if_valid = ifv; bus.if_inst = inst; bus.if_pc = pc; bus.ex_ready = exr;
    bus.ex_valid = exv; bus.ex_is_load = exl; bus.ex_rd = rd; bus.ex_redirect = red;
    #1;
    u = uses(m_inst);
    haz = m_mode == 0 && m_v && exv && exl && rd != 0 &&
          ((u[1] && m_inst[19:15] == rd) || (u[0] && m_inst[24:20] == rd));
    eiv = m_mode == 2 ? 1'b0 : m_mode == 1 ? m_v : (m_v && !haz);
    eir = !m_v || (eiv && exr);
    check_outputs(eiv, eir);
    if (red) begin
      m_fl = m_fl < SAT ? m_fl + 1 : SAT;
      m_v = 0; m_mode = 2; m_fc = FC;
    end else begin
      if (m_mode != 2 && eir) begin
        m_v = ifv;
        if (ifv) begin m_inst = inst; m_pc = pc; end
      end
      if (m_mode == 0 && haz) begin
        m_mode = 1; m_sc = m_sc < SAT ? m_sc + 1 : SAT;
      end else if (m_mode == 1) m_mode = 0;
      else if (m_mode == 2 && ifv) begin
        m_fc--;
        if (m_fc == 0) m_mode = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    bus.if_valid = 0; bus.if_inst = '0; bus.if_pc = '0; bus.ex_ready = 0;
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_rd = '0; bus.ex_redirect = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, ADDI, 64'(4 * i), 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 0, 0, 0, 0);
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);
    step(1, ADD, 16, 1, 0, 0, 0, 0);
    step(1, ADDI, 20, 1, 1, 1, 5, 0);
    step(1, ADDI, 20, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 0, 0, 0, 0);
    chk("loaduse_stall_cnt", 64'(stall_cnt), 64'd1);
    step(1, ADD, 24, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 1, 1, 0, 0);
    step(1, LUI, 28, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 1, 1, 5, 0);
    chk("nohaz_stall_cnt", 64'(stall_cnt), 64'd1);
    step(1, ADDI, 32, 1, 0, 0, 0, 0);
    step(1, ADDI, 36, 1, 0, 0, 0, 1);
    step(1, ADDI, 40, 1, 0, 0, 0, 0);
    step(1, ADDI, 44, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 0, 0, 0, 0);
    chk("redirect_flush_cnt", 64'(flush_cnt), 64'd1);
    step(1, ADD, 48, 1, 0, 0, 0, 0);
    step(1, ADDI, 52, 1, 1, 1, 5, 1);
    step(1, ADDI, 56, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 0, 0, 0, 0);
    chk("redir_stall_cnt", 64'(stall_cnt), 64'd1);
    chk("redir_flush_cnt", 64'(flush_cnt), 64'd2);
    step(1, ADDI, 60, 1, 0, 0, 0, 0);
    repeat (3) step(1, ADDI, 64, 0, 0, 0, 0, 0);
    step(1, ADDI, 64, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 0, 0, 0, 0);
    repeat (3000)
      step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
           $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    repeat (20) begin
      step(1, ADD, 68, 1, 0, 0, 0, 0);
      step(0, NOP, 0, 1, 1, 1, 7, 0);
      step(0, NOP, 0, 1, 0, 0, 0, 0);
    end
    chk("stall_sat", 64'(stall_cnt), 64'(SAT));
    repeat (20) step(1, ADDI, 72, 1, 0, 0, 0, 1);
    chk("flush_sat", 64'(flush_cnt), 64'(SAT));
    step(1, ADD, 76, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, ADDI, 80, 1, 0, 0, 0, 0);
    step(0, NOP, 0, 1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
